// File: rtl/coherence_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coherence_bus_ctrl
// Purpose  : Bus-side responder for two snooping data caches. Arbitrates the
//            caches' word requests onto the single RAM port. A coherent miss
//            (cctrans) first snoops the peer cache, which may invalidate its
//            copy or supply a dirty block cache-to-cache (memory is written in
//            the same transfer).
// Macro    : COHERENCE_SNOOP_EN - enables SNOOP/SNRESP/C2C states. When it is
//            undefined, cctrans/ccwrite are ignored and ccwait/ccinv/
//            ccsnoopaddr are tied to 0.
// Ports    : CLK, nRST (async, active-low)
//            dREN/dWEN/daddr/dstore/cctrans/ccwrite  - per-cache requests
//            dwait/dload/ccwait/ccinv/ccsnoopaddr    - per-cache responses
//            ramstate/ramload (in), ramREN/ramWEN/ramaddr/ramstore (out)
// Revision : 1.0 - initial release
// ============================================================================
module coherence_bus_ctrl #(
  parameter int CPUS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  input  logic [CPUS-1:0]        cctrans,
  input  logic [CPUS-1:0]        ccwrite,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  dload,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS-1:0][31:0]  ccsnoopaddr,
  input  logic [1:0]             ramstate,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload
);

  typedef enum logic [1:0] {
    c_FREE   = 2'd0,
    c_BUSY   = 2'd1,
    c_ACCESS = 2'd2,
    c_ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [3:0] {
    c_IDLE   = 4'd0,
    c_SNOOP  = 4'd1,
    c_SNRESP = 4'd2,
    c_C2C1   = 4'd3,
    c_C2C2   = 4'd4,
    c_LD1    = 4'd5,
    c_LD2    = 4'd6,
    c_WB1    = 4'd7,
    c_WB2    = 4'd8
  } state_t;

  state_t       r_state;
  logic         r_req;   // cache being served
  logic         r_snp;   // its peer
  logic         r_rr;    // round-robin preference on contention
  logic [1:0]   w_pend;
  logic         w_win;
  logic         w_access;

  assign w_access = (ramstate == c_ACCESS);
  assign w_pend   = dREN | dWEN;
  // Single requester wins outright; on contention the rr pointer decides.
  assign w_win    = w_pend[0] ? (w_pend[1] ? r_rr : 1'b0) : 1'b1;

`ifdef COHERENCE_SNOOP_EN
  logic r_coh;  // current read is a coherent two-word block fill
`else
  logic w_unused_cc;
  assign w_unused_cc = ^{cctrans, ccwrite};
  assign ccwait      = '0;
  assign ccinv       = '0;
  assign ccsnoopaddr = '0;
`endif

  // --------------------------------------------------------------------------
  // State register. Only ACCESS advances a RAM/C2C state; FREE, BUSY and
  // ERROR all hold so the word is retried indefinitely.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= c_IDLE;
      r_req   <= 1'b0;
      r_snp   <= 1'b1;
      r_rr    <= 1'b0;
`ifdef COHERENCE_SNOOP_EN
      r_coh   <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (|w_pend) begin
            r_req <= w_win;
            r_snp <= ~w_win;
            if (dWEN[w_win]) begin
              r_state <= c_WB1;
`ifdef COHERENCE_SNOOP_EN
            end else if (cctrans[w_win]) begin
              r_state <= c_SNOOP;
              r_coh   <= 1'b1;
            end else begin
              r_state <= c_LD1;
              r_coh   <= 1'b0;
`else
            end else begin
              r_state <= c_LD1;
`endif
            end
          end
        end
        c_WB1: if (w_access) r_state <= c_WB2;
        c_WB2: if (w_access) begin
          r_state <= c_IDLE;
          r_rr    <= r_snp;
        end
        c_LD1: if (w_access) begin
`ifdef COHERENCE_SNOOP_EN
          if (r_coh) begin
            r_state <= c_LD2;
          end else begin
            r_state <= c_IDLE;
            r_rr    <= r_snp;
          end
`else
          r_state <= c_IDLE;
          r_rr    <= r_snp;
`endif
        end
        c_LD2: if (w_access) begin
          r_state <= c_IDLE;
          r_rr    <= r_snp;
        end
`ifdef COHERENCE_SNOOP_EN
        c_SNOOP:  r_state <= c_SNRESP;
        // Peer asserting dWEN in the response cycle means it holds the block dirty.
        c_SNRESP: r_state <= dWEN[r_snp] ? c_C2C1 : c_LD1;
        c_C2C1:   if (w_access) r_state <= c_C2C2;
        c_C2C2:   if (w_access) begin
          r_state <= c_IDLE;
          r_rr    <= r_snp;
        end
`endif
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs are combinational from state and ramstate so dwait drops in the
  // very first ACCESS cycle. IDLE drives the reset values.
  // --------------------------------------------------------------------------
  always_comb begin
    dwait    = '1;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
`ifdef COHERENCE_SNOOP_EN
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
`endif
    case (r_state)
      c_WB1, c_WB2: begin
        ramWEN        = 1'b1;
        ramaddr       = daddr[r_req];
        ramstore      = dstore[r_req];
        dwait[r_req]  = ~w_access;
      end
      c_LD1, c_LD2: begin
        ramREN        = 1'b1;
        ramaddr       = daddr[r_req];
        dload[r_req]  = ramload;
        dwait[r_req]  = ~w_access;
      end
`ifdef COHERENCE_SNOOP_EN
      c_SNOOP, c_SNRESP: begin
        ccwait[r_snp]      = 1'b1;
        ccsnoopaddr[r_snp] = daddr[r_req];
        ccinv[r_snp]       = ccwrite[r_req];
      end
      c_C2C1, c_C2C2: begin
        // Peer's dirty word goes to the requester and to memory at once.
        ramWEN        = 1'b1;
        ramaddr       = daddr[r_snp];
        ramstore      = dstore[r_snp];
        dload[r_req]  = dstore[r_snp];
        if (w_access) dwait = '0;
      end
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire
